// File: rtl/mcse_lc_pkg.sv
// Shared types for the MCSE lifecycle-transition controller.
package mcse_lc_pkg;

    localparam int unsigned LC_RAW = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_WAIT_AUTH,
        ST_COMMIT,
        ST_LOCKED
    } lc_fsm_e;

    typedef enum logic [1:0] {
        RESP_OK        = 2'b00,
        RESP_ILLEGAL   = 2'b01,
        RESP_AUTH_FAIL = 2'b10,
        RESP_TIMEOUT   = 2'b11
    } lc_resp_e;

endpackage

// File: rtl/mcse_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping modulo N. The pointer register is owned by the caller.
module mcse_rr_arbiter #(
    parameter int unsigned N     = 2,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [N-1:0] w_req_hi;
    logic         w_found;

    // Search the upper segment [ptr, N) first, then wrap to [0, ptr).
    always_comb begin
        w_req_hi = '0;
        w_found  = 1'b0;
        gnt      = '0;
        gnt_idx  = '0;
        for (int i = 0; i < int'(N); i++) begin
            w_req_hi[i] = req[i] && (i >= int'(ptr));
        end
        for (int i = 0; i < int'(N); i++) begin
            if (!w_found && w_req_hi[i]) begin
                w_found = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < int'(N); i++) begin
            if (!w_found && req[i]) begin
                w_found = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mcse_lc_ctrl.sv
// Lifecycle-transition controller: round-robin request arbitration, forward-only
// transitions, ID authentication within a bounded window, sticky lockout on repeated failures.
module mcse_lc_ctrl
    import mcse_lc_pkg::*;
#(
    parameter int unsigned N_REQ    = 2,
    parameter int unsigned ID_W     = 256,
    parameter int unsigned LC_W     = 3,
    parameter int unsigned MAX_FAIL = 3,
    parameter int unsigned TIMEOUT  = 1024,
    localparam int unsigned IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int unsigned FAIL_W  = $clog2(MAX_FAIL + 1),
    localparam int unsigned TMR_W   = $clog2(TIMEOUT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*LC_W-1:0]   req_target,
    input  logic [N_REQ*ID_W-1:0]   req_id,
    output logic [N_REQ-1:0]        req_ack,
    input  logic [ID_W-1:0]         auth_id,
    input  logic                    auth_valid,
    output logic                    resp_valid,
    output logic [1:0]              resp_code,
    output logic [IDX_W-1:0]        resp_idx,
    output logic [LC_W-1:0]         lc_state,
    output logic                    busy,
    output logic                    locked,
    output logic [FAIL_W-1:0]       fail_cnt
);

    lc_fsm_e             r_state;
    logic [LC_W-1:0]     r_lc_state;
    logic [FAIL_W-1:0]   r_fail_cnt;
    logic                r_locked;
    logic [N_REQ-1:0]    r_req_ack;
    logic                r_resp_valid;
    lc_resp_e            r_resp_code;
    logic [IDX_W-1:0]    r_resp_idx;
    logic                r_busy;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    r_idx;
    logic [LC_W-1:0]     r_target;
    logic [ID_W-1:0]     r_id;
    logic [TMR_W-1:0]    r_timer;

    logic [N_REQ-1:0]    w_gnt;
    logic [IDX_W-1:0]    w_gnt_idx;
    logic [IDX_W-1:0]    w_next_ptr;
    logic [LC_W-1:0]     w_tgt_arr [N_REQ];
    logic [ID_W-1:0]     w_id_arr  [N_REQ];
    logic [LC_W-1:0]     w_sel_target;
    logic [ID_W-1:0]     w_sel_id;
    logic [FAIL_W-1:0]   w_fail_inc;
    logic                w_fail_lock;
    logic                w_auth_match;
    logic                w_timer_last;

    mcse_rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    for (genvar g = 0; g < int'(N_REQ); g++) begin : g_unpack
        assign w_tgt_arr[g] = req_target[g*LC_W +: LC_W];
        assign w_id_arr[g]  = req_id[g*ID_W +: ID_W];
    end

    // One-hot mux of the granted requester's payload.
    always_comb begin
        w_sel_target = '0;
        w_sel_id     = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (w_gnt[i]) begin
                w_sel_target = w_tgt_arr[i];
                w_sel_id     = w_id_arr[i];
            end
        end
    end

    assign w_next_ptr   = (w_gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
    assign w_fail_inc   = r_fail_cnt + FAIL_W'(1);
    assign w_fail_lock  = (w_fail_inc == FAIL_W'(MAX_FAIL));
    assign w_auth_match = auth_valid && (auth_id == r_id);
    assign w_timer_last = (r_timer == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_lc_state   <= LC_W'(LC_RAW);
            r_fail_cnt   <= '0;
            r_locked     <= 1'b0;
            r_req_ack    <= '0;
            r_resp_valid <= 1'b0;
            r_resp_code  <= RESP_OK;
            r_resp_idx   <= '0;
            r_busy       <= 1'b0;
            r_ptr        <= '0;
            r_idx        <= '0;
            r_target     <= '0;
            r_id         <= '0;
            r_timer      <= '0;
        end else begin
            r_req_ack    <= '0;
            r_resp_valid <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        r_req_ack <= w_gnt;
                        r_idx     <= w_gnt_idx;
                        r_target  <= w_sel_target;
                        r_id      <= w_sel_id;
                        r_ptr     <= w_next_ptr;
                        r_busy    <= 1'b1;
                        r_state   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (r_target > r_lc_state) begin
                        r_timer <= '0;
                        r_state <= ST_WAIT_AUTH;
                    end else begin
                        r_resp_valid <= 1'b1;
                        r_resp_code  <= RESP_ILLEGAL;
                        r_resp_idx   <= r_idx;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                ST_WAIT_AUTH: begin
                    // An auth on the final window edge wins over the timeout.
                    if (w_auth_match) begin
                        r_state <= ST_COMMIT;
                    end else if (auth_valid || w_timer_last) begin
                        r_fail_cnt   <= w_fail_inc;
                        r_resp_valid <= 1'b1;
                        r_resp_code  <= auth_valid ? RESP_AUTH_FAIL : RESP_TIMEOUT;
                        r_resp_idx   <= r_idx;
                        if (w_fail_lock) begin
                            r_locked <= 1'b1;
                            r_state  <= ST_LOCKED;
                        end else begin
                            r_busy   <= 1'b0;
                            r_state  <= ST_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                ST_COMMIT: begin
                    r_lc_state   <= r_target;
                    r_fail_cnt   <= '0;
                    r_resp_valid <= 1'b1;
                    r_resp_code  <= RESP_OK;
                    r_resp_idx   <= r_idx;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                ST_LOCKED: begin
                    r_locked <= 1'b1;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ack    = r_req_ack;
    assign resp_valid = r_resp_valid;
    assign resp_code  = r_resp_code;
    assign resp_idx   = r_resp_idx;
    assign lc_state   = r_lc_state;
    assign busy       = r_busy;
    assign locked     = r_locked;
    assign fail_cnt   = r_fail_cnt;

endmodule

// File: tb/tb_mcse_lc_ctrl.sv
// Scoreboard bench for mcse_lc_ctrl: stimulus queues expected acks/responses,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_mcse_lc_ctrl;

    localparam int unsigned N_REQ    = 2;
    localparam int unsigned ID_W     = 256;
    localparam int unsigned LC_W     = 3;
    localparam int unsigned MAX_FAIL = 3;
    localparam int unsigned TIMEOUT  = 16;

    localparam logic [1:0] C_OK   = 2'b00;
    localparam logic [1:0] C_ILL  = 2'b01;
    localparam logic [1:0] C_AUTH = 2'b10;
    localparam logic [1:0] C_TMO  = 2'b11;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*LC_W-1:0] req_target;
    logic [N_REQ*ID_W-1:0] req_id;
    logic [N_REQ-1:0]      req_ack;
    logic [ID_W-1:0]       auth_id;
    logic                  auth_valid;
    logic                  resp_valid;
    logic [1:0]            resp_code;
    logic [0:0]            resp_idx;
    logic [LC_W-1:0]       lc_state;
    logic                  busy;
    logic                  locked;
    logic [1:0]            fail_cnt;

    mcse_lc_ctrl #(
        .N_REQ    (N_REQ),
        .ID_W     (ID_W),
        .LC_W     (LC_W),
        .MAX_FAIL (MAX_FAIL),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_target (req_target),
        .req_id     (req_id),
        .req_ack    (req_ack),
        .auth_id    (auth_id),
        .auth_valid (auth_valid),
        .resp_valid (resp_valid),
        .resp_code  (resp_code),
        .resp_idx   (resp_idx),
        .lc_state   (lc_state),
        .busy       (busy),
        .locked     (locked),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] code;
        int         idx;
        int         lc;
        int         fcnt;
        int         lck;
        int         cyc;
    } rexp_t;

    typedef struct {
        logic [N_REQ-1:0] ack;
        int               cyc;
    } aexp_t;

    rexp_t rq[$];
    aexp_t aq[$];
    rexp_t m_r;
    aexp_t m_a;
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every presented ack / response against the queues.
    always @(negedge clk) begin
        if (req_ack != '0) begin
            if (aq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got %b expected none (cycle %0d)", req_ack, cyc);
            end else begin
                m_a = aq.pop_front();
                chk("ack_vec", int'(req_ack), int'(m_a.ack));
                chk("ack_cycle", cyc, m_a.cyc);
            end
        end
        if (resp_valid) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got code %0d idx %0d expected none (cycle %0d)",
                         resp_code, resp_idx, cyc);
            end else begin
                m_r = rq.pop_front();
                chk("resp_code", int'(resp_code), int'(m_r.code));
                chk("resp_idx", int'(resp_idx), m_r.idx);
                chk("resp_lc_state", int'(lc_state), m_r.lc);
                chk("resp_fail_cnt", int'(fail_cnt), m_r.fcnt);
                chk("resp_locked", int'(locked), m_r.lck);
                chk("resp_cycle", cyc, m_r.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_lc_state", int'(lc_state), 0);
        chk("rst_fail_cnt", int'(fail_cnt), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_req_ack", int'(req_ack), 0);
        chk("rst_resp_code", int'(resp_code), 0);
        chk("rst_resp_idx", int'(resp_idx), 0);
    endtask

    // mode: 0 illegal (no auth), 1 matching auth after d WAIT_AUTH cycles,
    // 2 mismatching auth after d cycles, 3 no auth (timeout).
    task automatic run_txn(input int i, input int tgt, input logic [ID_W-1:0] id,
                           input int mode, input int d, input logic [1:0] code,
                           input int elc, input int ef, input int el);
        int c;
        int rc;
        step();
        c = cyc;
        req_valid[i] = 1'b1;
        req_target[i*LC_W +: LC_W] = LC_W'(tgt);
        req_id[i*ID_W +: ID_W] = id;
        aq.push_back('{ack: N_REQ'(1 << i), cyc: c + 1});
        case (mode)
            0:       rc = c + 2;
            1:       rc = c + 4 + d;
            2:       rc = c + 3 + d;
            default: rc = c + 2 + int'(TIMEOUT);
        endcase
        rq.push_back('{code: code, idx: i, lc: elc, fcnt: ef, lck: el, cyc: rc});
        step();
        req_valid[i] = 1'b0;
        if (mode == 1 || mode == 2) begin
            repeat (d + 1) step();
            auth_valid = 1'b1;
            auth_id    = (mode == 1) ? id : ~id;
            step();
            auth_valid = 1'b0;
        end
        while (cyc < rc + 1) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [ID_W-1:0] id_a5;
        logic [ID_W-1:0] id_3c;
        int c;
        int got[2];
        id_a5 = {32{8'hA5}};
        id_3c = {32{8'h3C}};
        got   = '{0, 0};

        rst        = 1'b1;
        req_valid  = '0;
        req_target = '0;
        req_id     = '0;
        auth_id    = '0;
        auth_valid = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        check_reset_outputs();

        // Forward transitions, illegal targets, auth on the last window edge.
        run_txn(0, 1, id_a5, 1, 0,  C_OK,  1, 0, 0);
        run_txn(1, 2, id_3c, 1, 3,  C_OK,  2, 0, 0);
        run_txn(1, 2, id_3c, 0, 0,  C_ILL, 2, 0, 0);
        run_txn(0, 1, id_a5, 0, 0,  C_ILL, 2, 0, 0);
        run_txn(0, 3, id_a5, 1, int'(TIMEOUT) - 1, C_OK, 3, 0, 0);

        // Round-robin: both requesters contend; pointer starts at 1 after last grant of 0.
        step();
        c = cyc;
        req_target = '0;
        req_valid  = 2'b11;
        for (int k = 0; k < 6; k++) begin
            aq.push_back('{ack: (k % 2 == 0) ? 2'b10 : 2'b01, cyc: c + 1 + 2*k});
            rq.push_back('{code: C_ILL, idx: (k % 2 == 0) ? 1 : 0, lc: 3, fcnt: 0, lck: 0,
                           cyc: c + 2 + 2*k});
        end
        for (int t = 0; t < 20; t++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (req_ack[i]) begin
                    got[i]++;
                    req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = (got[i] < 3);
                end
            end
        end
        req_valid = '0;
        chk("rr_grants_req0", got[0], 3);
        chk("rr_grants_req1", got[1], 3);

        // Lockout sequence; ILLEGAL in between must not touch fail_cnt.
        run_txn(1, 5, id_3c, 2, 0, C_AUTH, 3, 1, 0);
        run_txn(0, 2, id_a5, 0, 0, C_ILL,  3, 1, 0);
        run_txn(0, 5, id_a5, 2, 2, C_AUTH, 3, 2, 0);
        run_txn(1, 6, id_3c, 3, 0, C_TMO,  3, 3, 1);

        // Locked: requests and auth must be ignored (monitor flags any ack/resp).
        step();
        req_valid[0] = 1'b1;
        req_target[0 +: LC_W] = 3'd7;
        req_id[0 +: ID_W] = id_a5;
        for (int t = 0; t < 6; t++) begin
            auth_valid = t[0];
            auth_id    = id_a5;
            step();
        end
        auth_valid = 1'b0;
        req_valid  = '0;
        step();
        chk("locked_flag", int'(locked), 1);
        chk("locked_busy", int'(busy), 1);
        chk("locked_lc_held", int'(lc_state), 3);
        chk("locked_fail_cnt", int'(fail_cnt), 3);

        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs();

        // Build up state, then abort a transaction mid-WAIT_AUTH with rst.
        run_txn(0, 1, id_a5, 1, 1, C_OK,   1, 0, 0);
        run_txn(1, 3, id_3c, 2, 0, C_AUTH, 1, 1, 0);
        step();
        c = cyc;
        req_valid[0] = 1'b1;
        req_target[0 +: LC_W] = 3'd3;
        req_id[0 +: ID_W] = id_a5;
        aq.push_back('{ack: 2'b01, cyc: c + 1});
        step();
        req_valid[0] = 1'b0;
        step();
        step();
        step();
        chk("abort_busy_before_rst", int'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs();
        repeat (20) step();

        run_txn(0, 7, id_a5, 1, 0, C_OK, 7, 0, 0);

        chk("ack_queue_empty", aq.size(), 0);
        chk("resp_queue_empty", rq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
